// File: rtl/phos_fec_v1_adc_zs_scanner.sv
// Zero-suppression scanner: snapshots 64 ADC channels on a trigger, subtracts pedestals,
// thresholds, and streams surviving {eoe, ch, value} words followed by one end-of-event word.
module phos_fec_v1_adc_zs_scanner #(
    parameter  int ADC_BITS     = 12,
    parameter  int ADC_CHIPS    = 2,
    parameter  int ADC_CHIP_NCH = 32,
    localparam int ADC_NCH      = ADC_CHIPS * ADC_CHIP_NCH,
    localparam int CH_W         = $clog2(ADC_NCH),
    localparam int WORD_W       = 1 + CH_W + ADC_BITS
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [ADC_NCH*ADC_BITS-1:0] adc_pdata_i,
    input  logic                        adc_valid_i,
    input  logic                        trig_i,
    input  logic                        zs_en_i,
    input  logic [ADC_BITS-1:0]         thr_i,
    input  logic                        ped_we_i,
    input  logic [CH_W-1:0]             ped_addr_i,
    input  logic [ADC_BITS-1:0]         ped_data_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [WORD_W-1:0]           m_data_o,
    output logic                        busy_o,
    output logic [15:0]                 evt_cnt_o,
    output logic [15:0]                 drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SCAN,
        ST_EOE
    } state_t;

    state_t state_q, state_d;

    logic [ADC_NCH-1:0][ADC_BITS-1:0] snap_q, snap_d;
    logic [ADC_NCH-1:0][ADC_BITS-1:0] ped_q, ped_d;
    logic                             zs_q, zs_d;
    logic [ADC_BITS-1:0]              thr_q, thr_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [CH_W:0]                    nword_q, nword_d;
    logic                             m_valid_q, m_valid_d;
    logic [WORD_W-1:0]                m_data_q, m_data_d;
    logic [15:0]                      evt_q, evt_d;
    logic [15:0]                      drop_q, drop_d;

    logic [ADC_BITS-1:0] cur_smp;
    logic [ADC_BITS-1:0] cur_ped;
    logic [ADC_BITS-1:0] diff;
    logic                pass;
    logic                accept;
    logic                busy;
    logic                last_ch;

    // Evaluation uses the registered pedestal, so a same-cycle write only lands next cycle.
    always_comb begin
        cur_smp = snap_q[ch_q];
        cur_ped = ped_q[ch_q];
        diff    = (cur_ped > cur_smp) ? '0 : (cur_smp - cur_ped);
        pass    = !zs_q || (diff > thr_q);
        accept  = !m_valid_q || m_ready_i;
        busy    = (state_q != ST_IDLE) || m_valid_q;
        last_ch = (ch_q == CH_W'(ADC_NCH - 1));
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ped_d     = ped_q;
        zs_d      = zs_q;
        thr_d     = thr_q;
        ch_d      = ch_q;
        nword_d   = nword_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        evt_d     = evt_q;
        drop_d    = drop_q;

        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (ped_we_i) begin
            ped_d[ped_addr_i] = ped_data_i;
        end

        if (trig_i && busy && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_i && !busy) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (adc_valid_i) begin
                    snap_d  = adc_pdata_i;
                    zs_d    = zs_en_i;
                    thr_d   = thr_i;
                    ch_d    = '0;
                    nword_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A passing channel waits for room in the output register; suppressed ones just advance.
                if (!pass || accept) begin
                    if (pass) begin
                        m_valid_d = 1'b1;
                        m_data_d  = {1'b0, ch_q, diff};
                        nword_d   = nword_q + 1'b1;
                    end
                    if (last_ch) begin
                        ch_d    = '0;
                        state_d = ST_EOE;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            ST_EOE: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = {1'b1, {CH_W{1'b0}}, ADC_BITS'(nword_q)};
                    evt_d     = evt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            ped_q     <= '0;
            zs_q      <= 1'b0;
            thr_q     <= '0;
            ch_q      <= '0;
            nword_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            evt_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            ped_q     <= ped_d;
            zs_q      <= zs_d;
            thr_q     <= thr_d;
            ch_q      <= ch_d;
            nword_q   <= nword_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            evt_q     <= evt_d;
            drop_q    <= drop_d;
        end
    end

    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign busy_o     = busy;
    assign evt_cnt_o  = evt_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_phos_fec_v1_adc_zs_scanner.sv
// Randomised bench for the ZS scanner: a channel-list reference model predicts every event's
// word stream, which is compared against the words captured from the valid/ready port.
module tb_phos_fec_v1_adc_zs_scanner;

    localparam int ADC_BITS = 12;
    localparam int NCH      = 64;
    localparam int CH_W     = 6;
    localparam int WORD_W   = 19;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i;
    logic [NCH*ADC_BITS-1:0]  adc_pdata_i;
    logic                     adc_valid_i;
    logic                     trig_i;
    logic                     zs_en_i;
    logic [ADC_BITS-1:0]      thr_i;
    logic                     ped_we_i;
    logic [CH_W-1:0]          ped_addr_i;
    logic [ADC_BITS-1:0]      ped_data_i;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic [WORD_W-1:0]        m_data_o;
    logic                     busy_o;
    logic [15:0]              evt_cnt_o;
    logic [15:0]              drop_cnt_o;

    phos_fec_v1_adc_zs_scanner dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .adc_pdata_i (adc_pdata_i),
        .adc_valid_i (adc_valid_i),
        .trig_i      (trig_i),
        .zs_en_i     (zs_en_i),
        .thr_i       (thr_i),
        .ped_we_i    (ped_we_i),
        .ped_addr_i  (ped_addr_i),
        .ped_data_i  (ped_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .busy_o      (busy_o),
        .evt_cnt_o   (evt_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int ped_m[NCH];
    int smp[NCH];
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] got_q[$];
    int stamp_q[$];
    int trig_offs[$];
    int exp_evt  = 0;
    int exp_drop = 0;
    int cap      = 0;
    int ready_mode = 1;
    bit noise = 1'b0;
    bit hold_pend = 1'b0;
    logic [WORD_W-1:0] prev_data;

    always @(posedge clk_i) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Ready generator: 0 = stalled, 1 = always ready, 2 = 30% duty random.
    initial begin
        m_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       m_ready_i = 1'b0;
                1:       m_ready_i = 1'b1;
                default: m_ready_i = ($urandom_range(99) < 30);
            endcase
        end
    end

    // Output monitor: records transfers and checks the word is held while stalled.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (hold_pend) begin
                checkOutput("hold_valid", 32'(m_valid_o), 32'd1);
                checkOutput("hold_data", 32'(m_data_o), 32'(prev_data));
            end
            if (m_valid_o && m_ready_i) begin
                got_q.push_back(m_data_o);
                stamp_q.push_back(cyc);
            end
            hold_pend = m_valid_o && !m_ready_i;
            prev_data = m_data_o;
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_ped(input int ch, input int val);
        ped_we_i   = 1'b1;
        ped_addr_i = CH_W'(ch);
        ped_data_i = ADC_BITS'(val);
        tick();
        ped_we_i   = 1'b0;
        ped_m[ch]  = val;
    endtask

    // Reference: saturating subtract, strict threshold, then an EOE word carrying the count.
    task automatic model_event(input bit zs, input int thr);
        int n;
        int d;
        n = 0;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
            d = (smp[i] > ped_m[i]) ? smp[i] - ped_m[i] : 0;
            if (!zs || d > thr) begin
                exp_q.push_back({1'b0, CH_W'(i), ADC_BITS'(d)});
                n++;
            end
        end
        exp_q.push_back({1'b1, CH_W'(0), ADC_BITS'(n)});
    endtask

    task automatic applyStimulus(input bit zs, input int thr);
        model_event(zs, thr);
        zs_en_i = zs;
        thr_i   = ADC_BITS'(thr);
        trig_i  = 1'b1;
        if (noise) begin
            adc_valid_i = 1'b1;
            for (int k = 0; k < NCH*ADC_BITS/32; k++) adc_pdata_i[k*32 +: 32] = $urandom;
        end
        tick();
        trig_i = 1'b0;
        for (int i = 0; i < NCH; i++) adc_pdata_i[i*ADC_BITS +: ADC_BITS] = ADC_BITS'(smp[i]);
        adc_valid_i = 1'b1;
        tick();
        adc_valid_i = 1'b0;
        cap = cyc;
        zs_en_i = 1'($urandom);
        thr_i   = ADC_BITS'($urandom);
        exp_evt++;
    endtask

    task automatic finish_event(input bit chk_lat, input int ped_off, input int ped_ch, input int ped_val);
        int iter;
        int off;
        int nmin;
        bit t;
        iter = 0;
        while ((got_q.size() < exp_q.size() || busy_o) && iter < 20000) begin
            off = cyc - cap;
            t = 1'b0;
            foreach (trig_offs[k]) if (trig_offs[k] == off) t = 1'b1;
            trig_i = t;
            if (off == ped_off) begin
                ped_we_i   = 1'b1;
                ped_addr_i = CH_W'(ped_ch);
                ped_data_i = ADC_BITS'(ped_val);
            end else begin
                ped_we_i = 1'b0;
            end
            if (noise) begin
                adc_valid_i = 1'($urandom);
                for (int k = 0; k < NCH*ADC_BITS/32; k++) adc_pdata_i[k*32 +: 32] = $urandom;
            end
            tick();
            if (off == ped_off) ped_m[ped_ch] = ped_val;
            iter++;
        end
        trig_i = 1'b0;
        ped_we_i = 1'b0;
        adc_valid_i = 1'b0;
        checkOutput("event_done", 32'(iter < 20000), 32'd1);
        checkOutput("nwords", 32'(got_q.size()), 32'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            checkOutput($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            if (chk_lat) checkOutput($sformatf("lat%0d", i), 32'(stamp_q[i]), 32'(cap + 1 + i));
        end
        checkOutput("evt_cnt", 32'(evt_cnt_o), 32'(exp_evt & 16'hFFFF));
        checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(exp_drop));
        got_q.delete();
        stamp_q.delete();
        trig_offs.delete();
    endtask

    initial begin
        int n1;
        rst_n_i = 1'b0;
        adc_pdata_i = '0;
        adc_valid_i = 1'b0;
        trig_i = 1'b0;
        zs_en_i = 1'b0;
        thr_i = '0;
        ped_we_i = 1'b0;
        ped_addr_i = '0;
        ped_data_i = '0;
        for (int i = 0; i < NCH; i++) ped_m[i] = 0;
        repeat (3) tick();
        checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
        checkOutput("rst_data", 32'(m_data_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_evt", 32'(evt_cnt_o), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);
        rst_n_i = 1'b1;
        tick();

        // Reset in the middle of a stalled event.
        for (int i = 0; i < 8; i++) write_ped(i * 5, 1 + $urandom_range(500));
        for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(4095);
        ready_mode = 0;
        applyStimulus(1'b0, 0);
        repeat (10) tick();
        checkOutput("stall_valid", 32'(m_valid_o), 32'd1);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(m_valid_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_data", 32'(m_data_o), 32'd0);
        checkOutput("midrst_evt", 32'(evt_cnt_o), 32'd0);
        checkOutput("midrst_drop", 32'(drop_cnt_o), 32'd0);
        for (int i = 0; i < NCH; i++) ped_m[i] = 0;
        exp_evt = 0;
        exp_drop = 0;
        tick();
        got_q.delete();
        stamp_q.delete();
        rst_n_i = 1'b1;
        ready_mode = 1;
        repeat (2) tick();

        // Ramp with suppression off; pedestals must be back to zero.
        for (int i = 0; i < NCH; i++) smp[i] = 16 * i;
        applyStimulus(1'b0, 0);
        finish_event(1'b1, -1, 0, 0);

        // Threshold is strict: diff 101 passes, diff 100 is suppressed.
        for (int i = 0; i < NCH; i++) write_ped(i, 50);
        for (int i = 0; i < NCH; i++) smp[i] = 60;
        smp[5] = 151;
        smp[40] = 150;
        applyStimulus(1'b1, 100);
        finish_event(1'b0, -1, 0, 0);

        // Saturating subtract and same-cycle pedestal write.
        for (int i = 0; i < NCH; i++) write_ped(i, 0);
        write_ped(3, 200);
        for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(4095);
        smp[3] = 100;
        smp[7] = 500;
        applyStimulus(1'b0, 0);
        finish_event(1'b1, 7, 7, 10);
        applyStimulus(1'b0, 0);
        finish_event(1'b1, -1, 0, 0);

        // Random backpressure, random pedestals and input noise outside ARM.
        ready_mode = 2;
        noise = 1'b1;
        for (int e = 0; e < 24; e++) begin
            for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(4095);
            write_ped($urandom_range(NCH - 1), $urandom_range(4095));
            write_ped($urandom_range(NCH - 1), $urandom_range(1000));
            if (e < 20) applyStimulus(1'b0, 0);
            else applyStimulus(1'b1, $urandom_range(4095));
            finish_event(1'b0, -1, 0, 0);
        end
        noise = 1'b0;

        // Triggers during SCAN and on the EOE transfer cycle are all dropped.
        ready_mode = 1;
        repeat (2) tick();
        for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(4095);
        for (int i = 0; i < NCH; i++) write_ped(i, 0);
        trig_offs = '{5, 20, 40, 65};
        exp_drop += 4;
        applyStimulus(1'b0, 0);
        finish_event(1'b1, -1, 0, 0);
        checkOutput("drop_four", 32'(drop_cnt_o), 32'd4);
        repeat (10) tick();
        checkOutput("no_extra_busy", 32'(busy_o), 32'd0);
        checkOutput("no_extra_words", 32'(got_q.size()), 32'd0);
        checkOutput("no_extra_evt", 32'(evt_cnt_o), 32'(exp_evt));

        // Drop counter saturation while the output is stalled.
        ready_mode = 0;
        repeat (2) tick();
        for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(4095);
        applyStimulus(1'b0, 0);
        n1 = 65534 - exp_drop;
        trig_i = 1'b1;
        repeat (n1) tick();
        trig_i = 1'b0;
        checkOutput("drop_fffe", 32'(drop_cnt_o), 32'hFFFE);
        trig_i = 1'b1;
        repeat (3) tick();
        trig_i = 1'b0;
        checkOutput("drop_sat", 32'(drop_cnt_o), 32'hFFFF);
        exp_drop = 65535;
        ready_mode = 1;
        finish_event(1'b0, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
